mccpu: RTL and testbench
========================

// Module: mccpu
// PURPOSE
//  Multi-cycle MIPS-subset core; successor to the single-cycle core, same ISA and datapath primitives.
//  - One unified memory port with valid/ready handshake, so instruction and data memory may insert wait states.
//  - FSM-sequenced: each instruction takes 3-5 cycles plus memory waits.
//  - Adds a retire pulse and sticky illegal-instruction halt.
//  - Sits between the testbench/SoC memory model and the existing RF, alu, EXT and mux blocks.
// PARAMETERS
//  PC_RESET   32'h0000_0000  PC value loaded on reset
//  DEBUG_EN   1              1: reg_sel/reg_data debug port live; 0: reg_data tied to 0
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   asynchronous, active-low reset
//  mem_req        out  1   memory transaction request (valid)
//  mem_we         out  1   1 = write, 0 = read; meaningful only while mem_req=1
//  mem_addr       out  32  byte address, word aligned
//  mem_wdata      out  32  store data
//  mem_rdata      in   32  load/fetch data; sampled on the edge where mem_req & mem_ready
//  mem_ready      in   1   memory completes current request this cycle
//  PC             out  32  PC of the instruction currently executing
//  instr_retired  out  1   one-cycle pulse in the final state of each instruction
//  illegal        out  1   sticky; set on an unsupported opcode/funct
//  reg_sel        in   5   debug register select
//  reg_data       out  32  debug register value (combinational from RF)
// BEHAVIOUR
//  - Reset (rst=0, async):
//    - PC=PC_RESET, state=FETCH; IR, A, B, ALUOut and MDR = 0.
//    - mem_req=0, mem_we=0, instr_retired=0, illegal=0.
//    - RF cleared; mem_req drops in the same cycle rst falls, even mid-transaction.
//  - FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
//  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. Hold until mem_ready=1, then IR<=mem_rdata, PC<=PC+4, go to DECODE.
//  - DECODE:
//    - A<=RF[rs], B<=RF[rt].
//    - ALUOut<=PC+(sext(imm16)<<2), the branch target; PC already +4.
//    - Unsupported opcode/funct -> HALT.
//  - EXEC:
//    - R-type/imm: ALUOut<=alu(A or shamt, B or ext imm); ->WB.
//    - lw/sw: ALUOut<=A+sext(imm); ->MEM.
//    - beq/bne: if taken, PC<=ALUOut; retire; ->FETCH.
//    - j: PC<={PC[31:28],imm26,2'b00}; ->FETCH.
//    - jal: same as j, plus RF[31]<=PC (the +4 value).
//    - jr: PC<=A; ->FETCH.
//  - MEM: mem_req=1, mem_addr=ALUOut, mem_we=(sw), mem_wdata=B. Hold until mem_ready.
//    - sw: retire, ->FETCH.
//    - lw: MDR<=mem_rdata, ->WB.
//  - WB: RF[dest]<=ALUOut or MDR; dest is rd (R-type) or rt (imm/lw). Retire, ->FETCH.
//  - Cycles with mem_ready tied 1: beq/bne/j/jal/jr 3, R-type/imm/sw 4, lw 5. Each ready-low cycle adds 1.
//  - Supported ISA: add, sub, and, or, slt, sll, srl, jr; addi, ori, lui, lw, sw, beq, bne, j, jal.
//  - Arithmetic: all PC/address math is 32-bit, wraps mod 2^32, no exceptions. Overflow on add/addi ignored.
//  - Writes to $0 are discarded; RF[0] always reads 0.
//  - instr_retired: exactly one cycle per completed instruction, never in HALT.
//  - HALT: mem_req=0, illegal=1; PC holds the address of the illegal instruction +4. Only rst exits.
//  - mem_ready is ignored while mem_req=0. mem_req and its address/data stay stable until accepted.
// STRUCTURE
//  - Shared header mccpu_defs.v:
//    - opcode/funct localparams and ALUOp codes shared with alu/ctrl.
//    - FSM state encoding (3-bit); NPC/WDSel/GPRSel select codes.
//  - Sub-module mc_ctrl: FSM plus per-state control decode (outputs mux selects, RF/IR/PC/MDR enables, mem_req/mem_we).
//  - Datapath in mccpu reuses RF, alu, EXT, mux2, mux4 unchanged; adds IR/A/B/ALUOut/MDR registers.
// TESTING
//  1. Reset mid-FETCH with mem_ready=0 -> mem_req=0 same cycle; after release, first mem_addr=PC_RESET.
//  2. addi $1,$0,5 ; add $2,$1,$1 with ready=1 -> $2=10 after 8 cycles; 2 retire pulses.
//  3. sw $2,0($0) then lw $3,0($0) with 2 wait states per access -> $3=10. sw takes 4+2 cycles, lw 5+2; fetches +2 each.
//  4. beq taken (offset -1) from PC=0x10 -> next fetch addr 0x10. bne not taken -> 0x14. jal at 0x20 -> $31=0x24.
//  5. Opcode 6'h3F -> illegal=1, mem_req stays 0, no retire pulses, PC=addr+4 until reset.
//  6. add $0,$1,$1 -> reg_data(sel=0)=0. lui $4,0xFFFF ; ori $4,$4,0xFFFF -> $4=0xFFFF_FFFF.

Source files
------------

// File: rtl/mccpu_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset core:
// opcodes, FSM states, datapath selects and the ALU.
package mccpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [4:0] {
        I_ADD, I_SUB, I_AND, I_OR, I_SLT,
        I_SLL, I_SRL, I_JR,
        I_ADDI, I_ORI, I_LUI, I_LW, I_SW,
        I_BEQ, I_BNE, I_J, I_JAL,
        I_BAD
    } instr_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
        ALU_SLT, ALU_SLL, ALU_SRL, ALU_PASSB
    } alu_op_t;

    typedef enum logic [1:0] {
        NPC_PC4, NPC_BR, NPC_JMP, NPC_JR
    } npc_sel_t;

    typedef enum logic [1:0] {
        WD_ALU, WD_MDR, WD_PC
    } wd_sel_t;

    typedef enum logic [1:0] {
        GPR_RD, GPR_RT, GPR_RA
    } gpr_sel_t;

    typedef enum logic [1:0] {
        EXT_SIGN, EXT_ZERO, EXT_LUI
    } ext_sel_t;

    typedef struct packed {
        logic     ir_we;
        logic     pc_we;
        npc_sel_t npc_sel;
        logic     ab_we;
        logic     alu_out_we;
        logic     alu_out_br;
        logic     mdr_we;
        logic     rf_we;
        wd_sel_t  wd_sel;
        gpr_sel_t gpr_sel;
        logic     mem_req;
        logic     mem_we;
        logic     mem_data;
        logic     retire;
    } ctrl_t;

    function automatic instr_t decode(input logic [31:0] ir);
        instr_t k;
        k = I_BAD;
        case (ir[31:26])
            OP_RTYPE: begin
                case (ir[5:0])
                    FN_ADD:  k = I_ADD;
                    FN_SUB:  k = I_SUB;
                    FN_AND:  k = I_AND;
                    FN_OR:   k = I_OR;
                    FN_SLT:  k = I_SLT;
                    FN_SLL:  k = I_SLL;
                    FN_SRL:  k = I_SRL;
                    FN_JR:   k = I_JR;
                    default: k = I_BAD;
                endcase
            end
            OP_ADDI: k = I_ADDI;
            OP_ORI:  k = I_ORI;
            OP_LUI:  k = I_LUI;
            OP_LW:   k = I_LW;
            OP_SW:   k = I_SW;
            OP_BEQ:  k = I_BEQ;
            OP_BNE:  k = I_BNE;
            OP_J:    k = I_J;
            OP_JAL:  k = I_JAL;
            default: k = I_BAD;
        endcase
        return k;
    endfunction

    function automatic logic [31:0] alu(
        input alu_op_t     op,
        input logic [31:0] x,
        input logic [31:0] y
    );
        logic [31:0] r;
        unique case (op)
            ALU_ADD:   r = x + y;
            ALU_SUB:   r = x - y;
            ALU_AND:   r = x & y;
            ALU_OR:    r = x | y;
            ALU_SLT:   r = {31'b0, $signed(x) < $signed(y)};
            ALU_SLL:   r = y << x[4:0];
            ALU_SRL:   r = y >> x[4:0];
            ALU_PASSB: r = y;
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mccpu_ctrl.sv
// Instruction sequencer: state register plus per-state
// control decode for the multi-cycle datapath.
module mccpu_ctrl
    import mccpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  instr_t kind,
    input  logic   eq,
    input  logic   mem_ready,
    output ctrl_t  ctl,
    output logic   illegal
);

    state_t state;
    state_t state_nxt;
    ctrl_t  c;

    logic is_br;
    logic is_jmp;
    logic is_ls;
    logic taken;

    assign is_br  = (kind == I_BEQ) || (kind == I_BNE);
    assign is_jmp = (kind == I_J) || (kind == I_JAL);
    assign is_ls  = (kind == I_LW) || (kind == I_SW);
    assign taken  = ((kind == I_BEQ) && eq) ||
                    ((kind == I_BNE) && !eq);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_FETCH;
        else      state <= state_nxt;
    end

    always_comb begin
        c         = '0;
        state_nxt = state;
        case (state)
            S_FETCH: begin
                c.mem_req = 1'b1;
                if (mem_ready) begin
                    c.ir_we   = 1'b1;
                    c.pc_we   = 1'b1;
                    c.npc_sel = NPC_PC4;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                c.ab_we      = 1'b1;
                c.alu_out_we = 1'b1;
                c.alu_out_br = 1'b1;
                state_nxt    = (kind == I_BAD) ? S_HALT
                                               : S_EXEC;
            end
            S_EXEC: begin
                unique case (1'b1)
                    is_br: begin
                        c.pc_we   = taken;
                        c.npc_sel = NPC_BR;
                        c.retire  = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    is_jmp: begin
                        c.pc_we   = 1'b1;
                        c.npc_sel = NPC_JMP;
                        c.rf_we   = (kind == I_JAL);
                        c.wd_sel  = WD_PC;
                        c.gpr_sel = GPR_RA;
                        c.retire  = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    (kind == I_JR): begin
                        c.pc_we   = 1'b1;
                        c.npc_sel = NPC_JR;
                        c.retire  = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    is_ls: begin
                        c.alu_out_we = 1'b1;
                        state_nxt    = S_MEM;
                    end
                    default: begin
                        c.alu_out_we = 1'b1;
                        state_nxt    = S_WB;
                    end
                endcase
            end
            S_MEM: begin
                c.mem_req  = 1'b1;
                c.mem_data = 1'b1;
                c.mem_we   = (kind == I_SW);
                if (mem_ready) begin
                    if (kind == I_SW) begin
                        c.retire  = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        c.mdr_we  = 1'b1;
                        state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                c.rf_we   = 1'b1;
                c.wd_sel  = (kind == I_LW) ? WD_MDR : WD_ALU;
                c.gpr_sel = (kind == I_ADDI || kind == I_ORI ||
                             kind == I_LUI  || kind == I_LW)
                            ? GPR_RT : GPR_RD;
                c.retire  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
        // state sits in FETCH during reset; keep the bus quiet
        c.mem_req = c.mem_req & rst;
        c.mem_we  = c.mem_we & rst;
        c.retire  = c.retire & rst;
    end

    assign ctl     = c;
    assign illegal = (state == S_HALT);

endmodule

// File: rtl/mccpu.sv
// Multi-cycle MIPS-subset core with a single
// valid/ready memory port shared by fetch and data.
module mccpu
    import mccpu_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter bit          DEBUG_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] PC,
    output logic        instr_retired,
    output logic        illegal,
    input  logic [4:0]  reg_sel,
    output logic [31:0] reg_data
);

    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu_out;
    logic [31:0] mdr;
    logic [31:0] rf [32];

    ctrl_t  ctl;
    instr_t kind;

    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] tgt;

    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign shamt = ir[10:6];
    assign imm   = ir[15:0];
    assign tgt   = ir[25:0];
    assign kind  = decode(ir);

    mccpu_ctrl u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .kind      (kind),
        .eq        (a == b),
        .mem_ready (mem_ready),
        .ctl       (ctl),
        .illegal   (illegal)
    );

    ext_sel_t    ext_sel;
    alu_op_t     alu_op;
    logic        use_imm;
    logic        use_sh;
    logic [31:0] ext;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic [31:0] br_tgt;
    logic [31:0] npc;
    logic [4:0]  dst;
    logic [31:0] wd;

    always_comb begin
        ext_sel = EXT_SIGN;
        alu_op  = ALU_ADD;
        use_imm = 1'b0;
        use_sh  = 1'b0;
        unique case (kind)
            I_SUB:  alu_op = ALU_SUB;
            I_AND:  alu_op = ALU_AND;
            I_OR:   alu_op = ALU_OR;
            I_SLT:  alu_op = ALU_SLT;
            I_SLL: begin
                alu_op = ALU_SLL;
                use_sh = 1'b1;
            end
            I_SRL: begin
                alu_op = ALU_SRL;
                use_sh = 1'b1;
            end
            I_ADDI, I_LW, I_SW: use_imm = 1'b1;
            I_ORI: begin
                alu_op  = ALU_OR;
                ext_sel = EXT_ZERO;
                use_imm = 1'b1;
            end
            I_LUI: begin
                alu_op  = ALU_PASSB;
                ext_sel = EXT_LUI;
                use_imm = 1'b1;
            end
            default: alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        unique case (ext_sel)
            EXT_ZERO: ext = {16'b0, imm};
            EXT_LUI:  ext = {imm, 16'b0};
            default:  ext = {{16{imm[15]}}, imm};
        endcase
    end

    assign alu_a   = use_sh ? {27'b0, shamt} : a;
    assign alu_b   = use_imm ? ext : b;
    assign alu_res = alu(alu_op, alu_a, alu_b);
    // pc already points past the branch when DECODE forms this
    assign br_tgt  = pc + {{14{imm[15]}}, imm, 2'b00};

    always_comb begin
        unique case (ctl.npc_sel)
            NPC_BR:  npc = alu_out;
            NPC_JMP: npc = {pc[31:28], tgt, 2'b00};
            NPC_JR:  npc = a;
            default: npc = pc + 32'd4;
        endcase
    end

    always_comb begin
        unique case (ctl.gpr_sel)
            GPR_RT:  dst = rt;
            GPR_RA:  dst = 5'd31;
            default: dst = rd;
        endcase
    end

    always_comb begin
        unique case (ctl.wd_sel)
            WD_MDR:  wd = mdr;
            WD_PC:   wd = pc;
            default: wd = alu_out;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= PC_RESET;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            if (ctl.pc_we) pc <= npc;
            if (ctl.ir_we) ir <= mem_rdata;
            if (ctl.ab_we) begin
                a <= rf[rs];
                b <= rf[rt];
            end
            if (ctl.alu_out_we)
                alu_out <= ctl.alu_out_br ? br_tgt : alu_res;
            if (ctl.mdr_we) mdr <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (ctl.rf_we && dst != 5'd0) begin
            rf[dst] <= wd;
        end
    end

    assign mem_req       = ctl.mem_req;
    assign mem_we        = ctl.mem_we;
    assign mem_addr      = ctl.mem_data ? alu_out : pc;
    assign mem_wdata     = b;
    assign PC            = pc;
    assign instr_retired = ctl.retire;

    generate
        if (DEBUG_EN) begin : g_dbg
            assign reg_data = rf[reg_sel];
        end else begin : g_nodbg
            assign reg_data = '0;
        end
    endgenerate

endmodule

// File: tb/tb_mccpu.sv
// Directed bench for mccpu: wait-state memory model,
// hand-assembled programs, cycle-exact checks.
module tb_mccpu;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] PC;
    logic        instr_retired;
    logic        illegal;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;

    logic [31:0] mem [0:255];
    int          ws   = 0;
    logic        hold = 1'b0;
    logic        clr  = 1'b0;
    logic        ld   = 1'b0;
    logic [7:0]  ld_a = '0;
    logic [31:0] ld_d = '0;
    int          cnt  = 0;
    int          nret = 0;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    mccpu #(
        .PC_RESET (32'h0000_0000),
        .DEBUG_EN (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .PC            (PC),
        .instr_retired (instr_retired),
        .illegal       (illegal),
        .reg_sel       (reg_sel),
        .reg_data      (reg_data)
    );

    assign mem_ready = mem_req && !hold && (cnt == ws);
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (instr_retired) nret <= nret + 1;
        if (!mem_req) cnt <= 0;
        else if (mem_ready) begin
            cnt <= 0;
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
        end else cnt <= cnt + 1;
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (ld) mem[ld_a] <= ld_d;
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] addr,
                       input logic [31:0] data);
        ld   = 1'b1;
        ld_a = addr[9:2];
        ld_d = data;
        run(1);
        ld   = 1'b0;
    endtask

    task automatic load_begin(input int wait_states);
        rst  = 1'b0;
        hold = 1'b0;
        ws   = wait_states;
        clr  = 1'b1;
        run(1);
        clr  = 1'b0;
    endtask

    task automatic peek(input logic [4:0] r,
                        output logic [31:0] v);
        reg_sel = r;
        #1;
        v = reg_data;
    endtask

    task automatic test_reset;
        rst  = 1'b0;
        hold = 1'b1;
        ws   = 0;
        clr  = 1'b1;
        run(1);
        clr  = 1'b0;
        total++;
        if (mem_req !== 1'b0 || illegal !== 1'b0 ||
            instr_retired !== 1'b0 || PC !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: req=%b ill=%b ret=%b pc=%h want 0 0 0 0",
                     mem_req, illegal, instr_retired, PC);
        end
        rst = 1'b1;
        run(3);
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0 || PC !== 32'h0) begin
            bad++;
            $display("FAIL fetch_hold: req=%b addr=%h pc=%h want 1 0 0",
                     mem_req, mem_addr, PC);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL reset_drop: req=%b we=%b want 0 0",
                     mem_req, mem_we);
        end
        hold = 1'b0;
        rst  = 1'b1;
        #1;
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            bad++;
            $display("FAIL first_fetch: req=%b addr=%h want 1 00000000",
                     mem_req, mem_addr);
        end
    endtask

    task automatic test_alu_seq;
        logic [31:0] v;
        int n0;
        load_begin(0);
        put(32'h00, 32'h2001_0005);
        put(32'h04, 32'h0021_1020);
        n0  = nret;
        rst = 1'b1;
        run(7);
        peek(5'd2, v);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL add_early: r2=%h want 0", v);
        end
        run(1);
        peek(5'd2, v);
        total++;
        if (v !== 32'd10) begin
            bad++;
            $display("FAIL add_result: r2=%h want a", v);
        end
        total++;
        if (nret - n0 !== 2 || mem_addr !== 32'h8) begin
            bad++;
            $display("FAIL add_retire: ret=%0d addr=%h want 2 8",
                     nret - n0, mem_addr);
        end
    endtask

    task automatic test_mem_wait;
        logic [31:0] v;
        int n0;
        load_begin(2);
        put(32'h00, 32'h2001_0005);
        put(32'h04, 32'h0021_1020);
        put(32'h08, 32'hAC02_0080);
        put(32'h0C, 32'h8C03_0080);
        n0  = nret;
        rst = 1'b1;
        run(19);
        total++;
        if (mem[32] !== 32'h0 || mem_req !== 1'b1 ||
            mem_we !== 1'b1 || mem_addr !== 32'h80 ||
            mem_wdata !== 32'd10) begin
            bad++;
            $display("FAIL sw_pending: m=%h req=%b we=%b a=%h d=%h want 0 1 1 80 a",
                     mem[32], mem_req, mem_we, mem_addr, mem_wdata);
        end
        run(1);
        total++;
        if (mem[32] !== 32'd10) begin
            bad++;
            $display("FAIL sw_done: mem=%h want a", mem[32]);
        end
        run(8);
        peek(5'd3, v);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL lw_early: r3=%h want 0", v);
        end
        run(1);
        peek(5'd3, v);
        total++;
        if (v !== 32'd10 || nret - n0 !== 4) begin
            bad++;
            $display("FAIL lw_done: r3=%h ret=%0d want a 4",
                     v, nret - n0);
        end
    endtask

    task automatic test_branch;
        logic [31:0] v;
        int n0;
        load_begin(0);
        put(32'h10, 32'h1000_FFFF);
        rst = 1'b1;
        run(18);
        total++;
        if (mem_req !== 1'b0) begin
            bad++;
            $display("FAIL beq_exec: req=%b want 0", mem_req);
        end
        run(1);
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h10 || PC !== 32'h10) begin
            bad++;
            $display("FAIL beq_taken: req=%b addr=%h pc=%h want 1 10 10",
                     mem_req, mem_addr, PC);
        end
        load_begin(0);
        put(32'h10, 32'h1400_FFFF);
        put(32'h14, 32'h0800_0008);
        put(32'h20, 32'h0C00_0010);
        n0  = nret;
        rst = 1'b1;
        run(19);
        total++;
        if (mem_addr !== 32'h14 || mem_req !== 1'b1) begin
            bad++;
            $display("FAIL bne_fall: addr=%h req=%b want 14 1",
                     mem_addr, mem_req);
        end
        run(3);
        total++;
        if (mem_addr !== 32'h20) begin
            bad++;
            $display("FAIL j_target: addr=%h want 20", mem_addr);
        end
        run(3);
        peek(5'd31, v);
        total++;
        if (mem_addr !== 32'h40 || v !== 32'h24 ||
            nret - n0 !== 7) begin
            bad++;
            $display("FAIL jal_link: addr=%h r31=%h ret=%0d want 40 24 7",
                     mem_addr, v, nret - n0);
        end
    endtask

    task automatic test_illegal;
        int n0;
        load_begin(0);
        put(32'h00, 32'hFC00_0000);
        n0  = nret;
        rst = 1'b1;
        run(1);
        total++;
        if (illegal !== 1'b0) begin
            bad++;
            $display("FAIL ill_early: illegal=%b want 0", illegal);
        end
        run(1);
        total++;
        if (illegal !== 1'b1 || mem_req !== 1'b0 || PC !== 32'h4) begin
            bad++;
            $display("FAIL ill_halt: ill=%b req=%b pc=%h want 1 0 4",
                     illegal, mem_req, PC);
        end
        run(10);
        total++;
        if (illegal !== 1'b1 || mem_req !== 1'b0 ||
            PC !== 32'h4 || nret - n0 !== 0) begin
            bad++;
            $display("FAIL ill_sticky: ill=%b req=%b pc=%h ret=%0d want 1 0 4 0",
                     illegal, mem_req, PC, nret - n0);
        end
        rst = 1'b0;
        #1;
        total++;
        if (illegal !== 1'b0 || PC !== 32'h0) begin
            bad++;
            $display("FAIL ill_reset: ill=%b pc=%h want 0 0",
                     illegal, PC);
        end
    endtask

    task automatic test_zero_lui;
        logic [31:0] v;
        load_begin(0);
        put(32'h00, 32'h2001_0005);
        put(32'h04, 32'h0021_0020);
        put(32'h08, 32'h3C04_FFFF);
        put(32'h0C, 32'h3484_FFFF);
        rst = 1'b1;
        run(12);
        peek(5'd4, v);
        total++;
        if (v !== 32'hFFFF_0000) begin
            bad++;
            $display("FAIL lui: r4=%h want ffff0000", v);
        end
        run(4);
        peek(5'd4, v);
        total++;
        if (v !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL ori: r4=%h want ffffffff", v);
        end
        peek(5'd0, v);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL r0_zero: r0=%h want 0", v);
        end
        peek(5'd1, v);
        total++;
        if (v !== 32'd5) begin
            bad++;
            $display("FAIL r1_keep: r1=%h want 5", v);
        end
        rst = 1'b0;
        #1;
        peek(5'd4, v);
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL rf_clear: r4=%h want 0", v);
        end
    endtask

    initial begin
        rst     = 1'b0;
        reg_sel = '0;
        test_reset();
        test_alu_seq();
        test_mem_wait();
        test_branch();
        test_illegal();
        test_zero_lui();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
